// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit words and writes them
// sequentially to instruction memory. Legality checking is enabled by `INSTR_ENC_CHECK_EN.
module instr_encoder #(
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          DEPTH     = 256,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [1:0]        sh,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       src2,
  input  logic [23:0]       imm24,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              err
);

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [1:0]  sh;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } fields_t;

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  localparam logic [1:0] OP_DP  = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR  = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  // Inverse of the decoder's field extraction; op 3 uses the data-processing layout.
  function automatic logic [31:0] pack(input fields_t f);
    logic [11:0] s2;
    s2 = f.src2;
    if (f.op == OP_DP && f.funct[4:1] == 4'd13)
      s2[6:5] = f.sh;
    if (f.op == OP_BR)
      pack = {f.cond, f.op, f.funct[5:4], f.imm24};
    else
      pack = {f.cond, f.op, f.funct, f.rn, f.rd, s2};
  endfunction

  fields_t     fin;
  logic        reject;
  state_t      state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] wdata_q, wdata_d;

  assign fin = '{cond: cond, op: op, funct: funct, sh: sh,
                 rn: rn, rd: rd, src2: src2, imm24: imm24};

`ifdef INSTR_ENC_CHECK_EN
  function automatic logic illegal(input fields_t f);
    illegal = 1'b0;
    if (f.op == OP_RSV)
      illegal = 1'b1;
    // Multiply encodings other than the plain form are not supported downstream.
    if (f.op == OP_DP && f.funct[5:4] == 2'b00 && f.funct[3:1] != 3'd0)
      illegal = 1'b1;
    if (f.op == OP_MEM && !f.funct[2])
      illegal = 1'b1;
  endfunction

  logic err_q;

  assign reject = illegal(fin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= !clear && state_q == IDLE && in_valid && reject;
  end

  assign err = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wdata_d = wdata_q;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !reject) begin
            wdata_d = pack(fin);
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (imem_ack) begin
            count_d = count_q + CW'(1);
            state_d = (count_d == CW'(DEPTH)) ? FULL : IDLE;
          end
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
    end
  end

  // Address follows count directly, so it is stable throughout WRITE and wraps silently.
  assign imem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'({count_q, 2'b00});
  assign imem_wdata = wdata_q;
  assign imem_we    = (state_q == WRITE);
  assign in_ready   = (state_q == IDLE);
  assign full       = (state_q == FULL);
  assign count      = count_q;

endmodule
